// File: rtl/pwm_carrier_sched.sv
// rtl/pwm_carrier_sched.sv - PWM carrier counter with boundary events, period shadow load and interrupt decimation
module pwm_carrier_sched #(
  parameter int PWMCOUNT_WIDTH = 16,
  parameter int DIVCLK_WIDTH   = 4,
  parameter int EVTCOUNT_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      carr_onoff,
  input  logic                      carr_sel,
  input  logic                      sync_in,
  input  logic [1:0]                count_mode,
  input  logic [1:0]                mask_mode,
  input  logic                      clkdiv_onoff,
  input  logic [DIVCLK_WIDTH-1:0]   clkdiv,
  input  logic [PWMCOUNT_WIDTH-1:0] period_sh,
  input  logic                      int_onoff,
  input  logic [EVTCOUNT_WIDTH-1:0] evt_prescale,
  input  logic                      int_ack,
  output logic [PWMCOUNT_WIDTH-1:0] carrier,
  output logic                      dir,
  output logic                      evt_min,
  output logic                      evt_max,
  output logic                      load_pulse,
  output logic [PWMCOUNT_WIDTH-1:0] period_act,
  output logic                      int_req
);

  localparam logic [1:0] NO_COUNT     = 2'd0;
  localparam logic [1:0] COUNT_UP     = 2'd1;
  localparam logic [1:0] COUNT_DOWN   = 2'd2;
  localparam logic [1:0] COUNT_UPDOWN = 2'd3;

  localparam logic [PWMCOUNT_WIDTH-1:0] CNT_ONE = PWMCOUNT_WIDTH'(1);
  localparam logic [DIVCLK_WIDTH-1:0]   DIV_ONE = DIVCLK_WIDTH'(1);
  localparam logic [EVTCOUNT_WIDTH-1:0] EVT_ONE = EVTCOUNT_WIDTH'(1);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  logic [PWMCOUNT_WIDTH-1:0] carrier_q, carrier_d;
  logic [PWMCOUNT_WIDTH-1:0] period_act_q, period_act_d;
  dir_e                      dir_q, dir_d;
  logic [DIVCLK_WIDTH-1:0]   div_cnt_q, div_cnt_d, div_run_d;
  logic [EVTCOUNT_WIDTH-1:0] evt_cnt_q, evt_cnt_d;
  logic                      evt_min_q, evt_min_d;
  logic                      evt_max_q, evt_max_d;
  logic                      load_q, load_d;
  logic                      int_req_q, int_req_d;
  logic                      tick;
  logic                      moved;
  logic                      int_set;

  // Prescaler: free-running divider that produces one tick per clkdiv+1 cycles
  always_comb begin
    tick      = 1'b1;
    div_run_d = '0;
    if (clkdiv_onoff) begin
      tick      = (div_cnt_q == clkdiv);
      div_run_d = tick ? '0 : div_cnt_q + DIV_ONE;
    end
  end

  // Carrier next state: off, sync restart, or one counting step per tick; events mark boundary entry
  always_comb begin
    carrier_d    = carrier_q;
    dir_d        = dir_q;
    div_cnt_d    = div_run_d;
    period_act_d = period_act_q;
    moved        = 1'b0;
    if (load_q) begin
      period_act_d = period_sh;
    end
    if (!carr_onoff) begin
      carrier_d    = '0;
      dir_d        = DIR_UP;
      div_cnt_d    = '0;
      period_act_d = period_sh;
    end else if (!carr_sel && sync_in) begin
      div_cnt_d = '0;
      dir_d     = DIR_UP;
      moved     = 1'b1;
      carrier_d = (count_mode == COUNT_DOWN) ? period_act_q : '0;
    end else if (tick && (count_mode != NO_COUNT)) begin
      moved = 1'b1;
      case (count_mode)
        COUNT_UP: begin
          dir_d     = DIR_UP;
          carrier_d = (carrier_q >= period_act_q) ? '0 : carrier_q + CNT_ONE;
        end
        COUNT_DOWN: begin
          dir_d     = DIR_DOWN;
          carrier_d = ((carrier_q == '0) || (carrier_q > period_act_q)) ? period_act_q
                                                                        : carrier_q - CNT_ONE;
        end
        COUNT_UPDOWN: begin
          if (period_act_q == '0) begin
            // A zero period pins the carrier; both boundaries coincide every tick
            carrier_d = '0;
            dir_d     = DIR_UP;
          end else if (dir_q == DIR_UP) begin
            if (carrier_q >= period_act_q) begin
              carrier_d = period_act_q - CNT_ONE;
              dir_d     = DIR_DOWN;
            end else begin
              carrier_d = carrier_q + CNT_ONE;
              dir_d     = ((carrier_q + CNT_ONE) == period_act_q) ? DIR_DOWN : DIR_UP;
            end
          end else begin
            if (carrier_q == '0) begin
              carrier_d = CNT_ONE;
              dir_d     = DIR_UP;
            end else begin
              carrier_d = carrier_q - CNT_ONE;
              dir_d     = (carrier_q == CNT_ONE) ? DIR_UP : DIR_DOWN;
            end
          end
        end
        default: begin
          carrier_d = carrier_q;
        end
      endcase
    end
    evt_min_d = moved && (carrier_d == '0);
    evt_max_d = moved && (carrier_d == period_act_q);
    load_d    = (evt_min_d && !mask_mode[0]) || (evt_max_d && !mask_mode[1]);
  end

  // Interrupt decimation: every evt_prescale+1 update events raise a sticky request
  always_comb begin
    evt_cnt_d = evt_cnt_q;
    int_set   = 1'b0;
    int_req_d = int_req_q;
    if (!int_onoff) begin
      evt_cnt_d = '0;
      int_req_d = 1'b0;
    end else begin
      if (load_d) begin
        if (evt_cnt_q == evt_prescale) begin
          evt_cnt_d = '0;
          int_set   = 1'b1;
        end else begin
          evt_cnt_d = evt_cnt_q + EVT_ONE;
        end
      end
      // A new request wins over an acknowledge in the same cycle
      if (int_set) begin
        int_req_d = 1'b1;
      end else if (int_ack) begin
        int_req_d = 1'b0;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      carrier_q    <= '0;
      dir_q        <= DIR_UP;
      div_cnt_q    <= '0;
      period_act_q <= '0;
      evt_cnt_q    <= '0;
      evt_min_q    <= 1'b0;
      evt_max_q    <= 1'b0;
      load_q       <= 1'b0;
      int_req_q    <= 1'b0;
    end else begin
      carrier_q    <= carrier_d;
      dir_q        <= dir_d;
      div_cnt_q    <= div_cnt_d;
      period_act_q <= period_act_d;
      evt_cnt_q    <= evt_cnt_d;
      evt_min_q    <= evt_min_d;
      evt_max_q    <= evt_max_d;
      load_q       <= load_d;
      int_req_q    <= int_req_d;
    end
  end

  assign carrier    = carrier_q;
  assign dir        = dir_q;
  assign evt_min    = evt_min_q;
  assign evt_max    = evt_max_q;
  assign load_pulse = load_q;
  assign period_act = period_act_q;
  assign int_req    = int_req_q;

endmodule
